// File: rtl/capture_ctrl.sv
// capture_ctrl: decimated, trigger-gated sample capture feeding the SDRAM write path
// Ports:
//   core_clk, core_rst_n       clock, asynchronous active-low reset
//   sample_en                  rise arms a capture, low aborts / returns to idle
//   sample_div                 sample tick every sample_div+1 cycles
//   sample_depth               post-trigger sample count (0 treated as 1)
//   trig_value, trig_mask      masked level trigger
//   trig_edge                  edge-qualify mask (only with CAPTURE_EDGE_TRIG_EN)
//   in_data, wfifo_full        probe bus, downstream FIFO full
//   capture_valid/_data        one-cycle sample strobe and held sample
//   capture_done               capture finished or aborted, stretched
//   sample_last_cnt            sample_depth-1 latched at arm
//   triggered, overflow        trigger seen, sticky emit-while-full
// Optional feature macro: CAPTURE_EDGE_TRIG_EN
module capture_ctrl #(
    parameter int DW           = 16,
    parameter int CW           = 32,
    parameter int DIVW         = 24,
    parameter int DONE_STRETCH = 8
) (
    input  logic            core_clk,
    input  logic            core_rst_n,
    input  logic            sample_en,
    input  logic [DIVW-1:0] sample_div,
    input  logic [CW-1:0]   sample_depth,
    input  logic [DW-1:0]   trig_value,
    input  logic [DW-1:0]   trig_mask,
`ifdef CAPTURE_EDGE_TRIG_EN
    input  logic [DW-1:0]   trig_edge,
`endif
    input  logic [DW-1:0]   in_data,
    input  logic            wfifo_full,
    output logic            capture_valid,
    output logic [DW-1:0]   capture_data,
    output logic            capture_done,
    output logic [CW-1:0]   sample_last_cnt,
    output logic            triggered,
    output logic            overflow
);
    localparam int SW = $clog2(DONE_STRETCH + 1);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t          state, state_nxt;
    logic            en_q, rise, arm, running, tick, hit, last, emit, stretch_ok, edge_hit;
    logic [DIVW-1:0] div_cnt;
    logic [CW-1:0]   count;
    logic [SW-1:0]   stretch;

`ifdef CAPTURE_EDGE_TRIG_EN
    logic [DW-1:0] prev;
    logic          prev_ok;

    // prev_ok keeps the first tick after arm from comparing against the cleared register
    assign edge_hit = (trig_edge == '0) || (prev_ok && ((in_data ^ prev) & trig_edge) == trig_edge);

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            prev    <= '0;
            prev_ok <= 1'b0;
        end else if (arm) begin
            prev    <= '0;
            prev_ok <= 1'b0;
        end else if (state == ARM && tick) begin
            prev    <= in_data;
            prev_ok <= 1'b1;
        end
    end
`else
    assign edge_hit = 1'b1;
`endif

    assign rise         = sample_en && !en_q;
    assign arm          = state == IDLE && rise;
    assign running      = state == ARM || state == CAPTURE;
    assign tick         = running && div_cnt == sample_div;
    assign hit          = ((in_data ^ trig_value) & trig_mask) == '0 && edge_hit;
    assign last         = state == ARM ? sample_last_cnt == '0 : count == sample_last_cnt;
    // an abort suppresses the tick's sample unless that tick completes the capture
    assign emit         = tick && (state == CAPTURE || hit) && (sample_en || last);
    // stretch counts DONE cycles already spent, so exit lands on the DONE_STRETCH-th cycle
    assign stretch_ok   = stretch >= SW'(DONE_STRETCH - 1);
    assign capture_done = state == DONE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         state_nxt = rise ? ARM : IDLE;
            ARM, CAPTURE: state_nxt = (!sample_en || (emit && last)) ? DONE : (emit ? CAPTURE : state);
            DONE:         state_nxt = (!sample_en && stretch_ok) ? IDLE : DONE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) state <= IDLE;
        else             state <= state_nxt;
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            en_q            <= 1'b0;
            div_cnt         <= '0;
            count           <= '0;
            stretch         <= '0;
            capture_valid   <= 1'b0;
            capture_data    <= '0;
            sample_last_cnt <= '0;
            triggered       <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            en_q          <= sample_en;
            capture_valid <= emit;
            stretch       <= state != DONE ? '0 : stretch + SW'(!stretch_ok);
            if (emit) capture_data <= in_data;
            if (capture_valid && wfifo_full) overflow <= 1'b1;
            if (running) div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (emit) count <= state == ARM ? CW'(1) : count + 1'b1;
            if (emit && state == ARM) triggered <= 1'b1;
            if (arm) begin
                div_cnt         <= '0;
                count           <= '0;
                triggered       <= 1'b0;
                overflow        <= 1'b0;
                sample_last_cnt <= sample_depth == '0 ? '0 : sample_depth - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: table-driven scoreboard bench for capture_ctrl
module tb_capture_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [23:0] sample_div;
    logic [31:0] sample_depth;
    logic [15:0] trig_value;
    logic [15:0] trig_mask;
`ifdef CAPTURE_EDGE_TRIG_EN
    logic [15:0] trig_edge;
`endif
    logic [15:0] in_data;
    logic        wfifo_full;
    logic        capture_valid;
    logic [15:0] capture_data;
    logic        capture_done;
    logic [31:0] sample_last_cnt;
    logic        triggered;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          div;
        logic [31:0] depth;
        logic [15:0] mask;
        logic [15:0] value;
        logic [15:0] base;
        int          drop;
        int          full_at;
        logic [31:0] exp_last;
        bit          exp_trig;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        int          j;
        logic [15:0] d;
    } exp_t;

    always #5 clk = ~clk;

    capture_ctrl dut (
        .core_clk       (clk),
        .core_rst_n     (rst_n),
        .sample_en      (sample_en),
        .sample_div     (sample_div),
        .sample_depth   (sample_depth),
        .trig_value     (trig_value),
        .trig_mask      (trig_mask),
`ifdef CAPTURE_EDGE_TRIG_EN
        .trig_edge      (trig_edge),
`endif
        .in_data        (in_data),
        .wfifo_full     (wfifo_full),
        .capture_valid  (capture_valid),
        .capture_data   (capture_data),
        .capture_done   (capture_done),
        .sample_last_cnt(sample_last_cnt),
        .triggered      (triggered),
        .overflow       (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done_low(input int bound);
        for (int i = 0; i < bound && capture_done; i++) @(negedge clk);
        chk("done_released", capture_done, 1'b0);
    endtask

    // Tick k after arm lands on cycle 1+div+(div+1)*k; in_data on cycle j is base+j.
    task automatic run_vec(input vec_t v);
        exp_t q[$];
        int   dep, trig_k, nstrobe, done_cnt, j;
        dep    = v.depth == 0 ? 1 : int'(v.depth);
        trig_k = -1;
        for (int k = 0; k < 200 && trig_k < 0; k++) begin
            int          tj;
            logic [15:0] d;
            tj = 1 + v.div + (v.div + 1) * k;
            d  = v.base + 16'(tj);
            if (((d ^ v.value) & v.mask) == 16'h0) trig_k = k;
        end
        for (int n = 0; trig_k >= 0 && n < dep && (v.drop == 0 || n < v.drop); n++) begin
            exp_t e;
            e.j = 1 + v.div + (v.div + 1) * (trig_k + n);
            e.d = v.base + 16'(e.j);
            q.push_back(e);
        end
        @(negedge clk);
        sample_div   = 24'(v.div);
        sample_depth = v.depth;
        trig_mask    = v.mask;
        trig_value   = v.value;
        in_data      = v.base;
        wfifo_full   = 1'b0;
        sample_en    = 1'b1;
        j        = 0;
        nstrobe  = 0;
        done_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            wfifo_full = 1'b0;
            if (j == 0) begin
                chk("arm_overflow_clear", overflow, 1'b0);
                chk("arm_triggered_clear", triggered, 1'b0);
                chk("last_cnt", sample_last_cnt, v.exp_last);
            end
            if (capture_valid) begin
                nstrobe++;
                if (q.size() == 0) chk("extra_strobe", capture_valid, 1'b0);
                else begin
                    chk("strobe_cycle", 32'(j), 32'(q[0].j));
                    chk("strobe_data", capture_data, q[0].d);
                    void'(q.pop_front());
                end
                if (nstrobe == v.full_at) wfifo_full = 1'b1;
                if (nstrobe == v.drop) sample_en = 1'b0;
            end
            j++;
            in_data = v.base + 16'(j);
            if (capture_done) break;
        end
        chk("done_seen", capture_done, 1'b1);
        chk("all_strobes_seen", q.size(), 0);
        done_cnt = 1;
        if (v.drop == 0) begin
            repeat (11) begin
                @(negedge clk);
                if (capture_done) done_cnt++;
            end
            chk("done_hold_while_en", done_cnt, 12);
            sample_en = 1'b0;
            @(negedge clk);
            chk("done_drop", capture_done, 1'b0);
        end else begin
            while (capture_done && done_cnt < 50) begin
                @(negedge clk);
                if (capture_done) done_cnt++;
            end
            chk("done_stretch", done_cnt, 8);
        end
        chk("idle_valid", capture_valid, 1'b0);
        chk("idle_last_cnt", sample_last_cnt, v.exp_last);
        chk("idle_triggered", triggered, v.exp_trig);
        chk("idle_overflow", overflow, v.exp_ovf);
    endtask

    initial begin
        vec_t tbl[6];
        int   nseen;
        tbl[0] = '{0, 32'd4,   16'h0000, 16'h0000, 16'h000F, 0,  0, 32'd3,  1'b1, 1'b0};
        tbl[1] = '{2, 32'd3,   16'h00FF, 16'h0042, 16'h1239, 0,  0, 32'd2,  1'b1, 1'b0};
        tbl[2] = '{0, 32'd0,   16'h0000, 16'h0000, 16'h0100, 0,  0, 32'd0,  1'b1, 1'b0};
        tbl[3] = '{3, 32'd100, 16'h0000, 16'h0000, 16'h0200, 10, 0, 32'd99, 1'b1, 1'b0};
        tbl[4] = '{1, 32'd5,   16'h0000, 16'h0000, 16'h0300, 0,  2, 32'd4,  1'b1, 1'b1};
        tbl[5] = '{0, 32'd2,   16'hFFFF, 16'h0005, 16'h0000, 0,  0, 32'd1,  1'b1, 1'b0};
        rst_n        = 1'b0;
        sample_en    = 1'b0;
        sample_div   = '0;
        sample_depth = '0;
        trig_value   = '0;
        trig_mask    = '0;
`ifdef CAPTURE_EDGE_TRIG_EN
        trig_edge    = '0;
`endif
        in_data      = '0;
        wfifo_full   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", capture_valid, 1'b0);
        chk("rst_done", capture_done, 1'b0);
        chk("rst_data", capture_data, 16'h0);
        chk("rst_last_cnt", sample_last_cnt, 32'h0);
        chk("rst_trig_ovf", {triggered, overflow}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // asynchronous reset in the middle of a capture
        @(negedge clk);
        sample_div   = '0;
        sample_depth = 32'd100;
        trig_mask    = '0;
        in_data      = 16'h0400;
        sample_en    = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", capture_valid, 1'b1);
        #2;
        rst_n     = 1'b0;
        sample_en = 1'b0;
        #1;
        chk("async_rst_valid", capture_valid, 1'b0);
        chk("async_rst_data", capture_data, 16'h0);
        chk("async_rst_done", capture_done, 1'b0);
        chk("async_rst_last", sample_last_cnt, 32'h0);
        chk("async_rst_trig_ovf", {triggered, overflow}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        nseen = 0;
        repeat (6) begin
            @(negedge clk);
            if (capture_valid || capture_done) nseen++;
        end
        chk("post_rst_quiet", nseen, 0);
        run_vec(tbl[0]);

`ifdef CAPTURE_EDGE_TRIG_EN
        @(negedge clk);
        trig_edge    = 16'h0001;
        sample_div   = '0;
        sample_depth = 32'd1;
        trig_mask    = '0;
        in_data      = 16'h0020;
        sample_en    = 1'b1;
        nseen        = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (capture_valid) begin
                nseen++;
                chk("edge_cycle", 32'(j), 32'd5);
                chk("edge_data", capture_data, 16'h0021);
            end
            in_data = (j + 1 >= 5) ? 16'h0021 : 16'h0020;
        end
        chk("edge_count", nseen, 1);
        sample_en = 1'b0;
        trig_edge = '0;
        wait_done_low(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
